// File: rtl/idu_issue_queue_pkg.sv
// Shared decode package: MIPS opcode/funct constants, the pre-decoded
// attribute bundle that travels with every instruction, and small helpers
// used by the instruction issue queue.
package idu_issue_queue_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL function codes (inst[5:0])
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [5:0] FN_SLTU    = 6'h2b;

    // Attribute bundle width and bit offsets within the packed vector
    localparam int ATTR_W         = 23;
    localparam int ATTR_RS_LSB    = 18;
    localparam int ATTR_RT_LSB    = 13;
    localparam int ATTR_W_ENA_BIT = 12;
    localparam int ATTR_W_DST_LSB = 7;
    localparam int ATTR_BRANCH    = 6;
    localparam int ATTR_LS        = 5;
    localparam int ATTR_HILO      = 4;
    localparam int ATTR_COP0      = 3;
    localparam int ATTR_RI        = 2;

    // Pre-decoded attributes; the two low bits are spare and carried as-is
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       w_ena;
        logic [4:0] w_dst;
        logic       is_branch;
        logic       is_ls;
        logic       is_hilo;
        logic       is_cop0;
        logic       is_ri;
        logic [1:0] rsvd;
    } idu_attr_t;

    // Number of occupied slots in a 2-bit valid vector of legal form
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        logic [1:0] n;
        n = 2'd0;
        if (v[0]) n = n + 2'd1;
        if (v[1]) n = n + 2'd1;
        return n;
    endfunction

    // Folds the illegal "slot 1 without slot 0" pattern to empty
    function automatic logic [1:0] legal_valid(input logic [1:0] v);
        return v[0] ? v : 2'b00;
    endfunction

endpackage

// File: rtl/idu_iq_pair_check.sv
// Dual-issue pairing rules for the two oldest queue entries: decides
// whether head+1 may issue alongside head, and whether a branch at the
// head must wait for its delay slot.
module idu_iq_pair_check
    import idu_issue_queue_pkg::*;
(
    input  idu_attr_t a0,
    input  idu_attr_t a1,
    input  logic      cnt_ge2,
    input  logic      dual_issue,
    output logic      pair_ok,
    output logic      hold
);

    logic raw_hazard;
    logic struct_hazard;
    logic serialize;
    logic unused_fields;

    // Hazard terms and the final pairing and branch-hold decisions
    always_comb begin
        raw_hazard    = a0.w_ena && (a0.w_dst != 5'd0) &&
                        ((a1.rs == a0.w_dst) || (a1.rt == a0.w_dst));
        struct_hazard = (a0.is_ls && a1.is_ls) || (a0.is_hilo && a1.is_hilo);
        serialize     = a0.is_cop0 || a0.is_ri || a1.is_cop0 || a1.is_ri;
        pair_ok       = dual_issue && cnt_ge2 && !raw_hazard && !struct_hazard &&
                        !serialize && !a1.is_branch;
        hold          = dual_issue && a0.is_branch && !cnt_ge2;
    end

    assign unused_fields = ^{a0.rs, a0.rt, a0.rsvd, a1.w_ena, a1.w_dst, a1.rsvd};

endmodule

// File: rtl/idu_issue_queue.sv
// Circular instruction issue queue between decode and issue: accepts up to
// two instructions per cycle and offers the two oldest to the issue stage,
// pairing them only when the pairing rules allow.
module idu_issue_queue
    import idu_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DUAL_ISSUE = 1
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [63:0]                in_pc,
    input  logic [63:0]                in_inst,
    input  logic [2*ATTR_W-1:0]        in_attr,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [63:0]                out_pc,
    output logic [63:0]                out_inst,
    output logic [2*ATTR_W-1:0]        out_attr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - 2);

    // Entry storage (not reset; validity is tracked by head/tail/count)
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    idu_attr_t   attr_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head_nx;
    logic [PTR_W-1:0] tail_nx;
    logic [1:0]       in_valid_legal;
    logic [1:0]       enq_num;
    logic [1:0]       deq_num;
    logic             enq_fire;
    logic             deq_fire;
    logic             cnt_ge1;
    logic             cnt_ge2;
    logic             pair_ok;
    logic             hold;
    idu_attr_t        head_a0;
    idu_attr_t        head_a1;
    idu_attr_t        in_a0;
    idu_attr_t        in_a1;

    // Pairing decision for the two entries at the head
    idu_iq_pair_check u_pair_check (
        .a0         (head_a0),
        .a1         (head_a1),
        .cnt_ge2    (cnt_ge2),
        .dual_issue (DUAL_ISSUE != 0),
        .pair_ok    (pair_ok),
        .hold       (hold)
    );

    // Head read port, occupancy flags and the issue/enqueue handshakes
    always_comb begin
        head_nx        = head_q + PTR_W'(1);
        tail_nx        = tail_q + PTR_W'(1);
        head_a0        = attr_mem[head_q];
        head_a1        = attr_mem[head_nx];
        in_a0          = in_attr[ATTR_W-1:0];
        in_a1          = in_attr[2*ATTR_W-1:ATTR_W];

        cnt_ge1        = (count_q != '0);
        cnt_ge2        = (count_q >= CNT_W'(2));
        in_ready       = (count_q <= READY_LIMIT);

        out_valid      = 2'b00;
        out_valid[0]   = cnt_ge1 && !flush && !hold;
        out_valid[1]   = out_valid[0] && pair_ok;
        out_pc         = {pc_mem[head_nx],   pc_mem[head_q]};
        out_inst       = {inst_mem[head_nx], inst_mem[head_q]};
        out_attr       = {head_a1, head_a0};
        count          = count_q;

        in_valid_legal = legal_valid(in_valid);
        enq_fire       = in_ready && in_valid_legal[0] && !flush;
        enq_num        = enq_fire ? slot_count(in_valid_legal) : 2'd0;
        deq_fire       = out_ready && out_valid[0];
        deq_num        = deq_fire ? slot_count(out_valid) : 2'd0;
    end

    // Next pointer/occupancy state; a flush empties the queue outright
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_num);
            tail_d  = tail_q + PTR_W'(enq_num);
            count_d = count_q + CNT_W'(enq_num) - CNT_W'(deq_num);
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry writes at tail and tail+1; the pair may straddle the wrap
    always_ff @(posedge clk) begin
        if (rst_n && enq_fire) begin
            pc_mem[tail_q]   <= in_pc[31:0];
            inst_mem[tail_q] <= in_inst[31:0];
            attr_mem[tail_q] <= in_a0;
            if (in_valid_legal[1]) begin
                pc_mem[tail_nx]   <= in_pc[63:32];
                inst_mem[tail_nx] <= in_inst[63:32];
                attr_mem[tail_nx] <= in_a1;
            end
        end
    end

endmodule

// File: tb/tb_idu_issue_queue.sv
// Directed bench for idu_issue_queue: a table of single-cycle vectors for
// the pairing, branch-hold and flush cases, then hand-written sequences for
// filling, wrap-around, reset mid-operation and single-issue mode.
module tb_idu_issue_queue;
    import idu_issue_queue_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [1:0]          in_valid;
    logic [63:0]         in_pc;
    logic [63:0]         in_inst;
    logic [2*ATTR_W-1:0] in_attr;
    logic                out_ready;

    logic                in_ready;
    logic [1:0]          out_valid;
    logic [63:0]         out_pc;
    logic [63:0]         out_inst;
    logic [2*ATTR_W-1:0] out_attr;
    logic [3:0]          count;

    logic                si_in_ready;
    logic [1:0]          si_out_valid;
    logic [63:0]         si_out_pc;
    logic [63:0]         si_out_inst;
    logic [2*ATTR_W-1:0] si_out_attr;
    logic [3:0]          si_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Free-running clock
    always #5 clk = ~clk;

    idu_issue_queue #(.DEPTH(8), .DUAL_ISSUE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_attr(in_attr),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_attr(out_attr), .out_ready(out_ready),
        .count(count)
    );

    idu_issue_queue #(.DEPTH(8), .DUAL_ISSUE(0)) u_dut_si (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_attr(in_attr),
        .in_ready(si_in_ready), .out_valid(si_out_valid), .out_pc(si_out_pc),
        .out_inst(si_out_inst), .out_attr(si_out_attr), .out_ready(out_ready),
        .count(si_count)
    );

    typedef struct {
        logic [1:0]  iv;
        logic [31:0] pc0;
        logic [31:0] inst0;
        idu_attr_t   a0;
        logic [31:0] pc1;
        logic [31:0] inst1;
        idu_attr_t   a1;
        logic        ordy;
        logic        fl;
        logic [1:0]  exp_ov;
        logic [3:0]  exp_cnt;
        logic        exp_rdy;
        logic [31:0] exp_pc0;
        logic [31:0] exp_inst0;
        logic [31:0] exp_pc1;
    } vec_t;

    vec_t vecs[13];

    function automatic idu_attr_t mk_attr(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic w, input logic [4:0] dst,
                                          input logic br, input logic ls, input logic hilo,
                                          input logic cop0, input logic ri);
        idu_attr_t a;
        a = '0;
        a.rs = rs; a.rt = rt; a.w_ena = w; a.w_dst = dst;
        a.is_branch = br; a.is_ls = ls; a.is_hilo = hilo; a.is_cop0 = cop0; a.is_ri = ri;
        return a;
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] iv,
                                    input logic [31:0] pc0, input logic [31:0] inst0, input idu_attr_t a0,
                                    input logic [31:0] pc1, input logic [31:0] inst1, input idu_attr_t a1,
                                    input logic ordy, input logic fl,
                                    input logic [1:0] exp_ov, input logic [3:0] exp_cnt, input logic exp_rdy,
                                    input logic [31:0] exp_pc0, input logic [31:0] exp_inst0,
                                    input logic [31:0] exp_pc1);
        vec_t v;
        v.iv = iv; v.pc0 = pc0; v.inst0 = inst0; v.a0 = a0;
        v.pc1 = pc1; v.inst1 = inst1; v.a1 = a1; v.ordy = ordy; v.fl = fl;
        v.exp_ov = exp_ov; v.exp_cnt = exp_cnt; v.exp_rdy = exp_rdy;
        v.exp_pc0 = exp_pc0; v.exp_inst0 = exp_inst0; v.exp_pc1 = exp_pc1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] iv,
                                 input logic [31:0] pc0, input logic [31:0] inst0, input idu_attr_t a0,
                                 input logic [31:0] pc1, input logic [31:0] inst1, input idu_attr_t a1,
                                 input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_pc     = {pc1, pc0};
        in_inst   = {inst1, inst0};
        in_attr   = {a1, a0};
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(2'b00, 32'h0, 32'h0, '0, 32'h0, 32'h0, '0, ordy, 1'b0);
    endtask

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        idu_attr_t A_ADDU3, A_ADDU5, A_LW, A_SW, A_OR6, A_BEQ, A_NOP;
        localparam logic [31:0] I_ADDU3 = 32'h00221821;
        localparam logic [31:0] I_ADDU5 = 32'h00642821;
        localparam logic [31:0] I_LW    = 32'h8D280000;
        localparam logic [31:0] I_SW    = 32'hAD6A0004;
        localparam logic [31:0] I_OR6   = 32'h00E83025;
        localparam logic [31:0] I_BEQ   = 32'h10220003;
        localparam logic [31:0] I_NOP   = 32'h00000000;

        A_ADDU3 = mk_attr(5'd1,  5'd2,  1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        A_ADDU5 = mk_attr(5'd3,  5'd4,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        A_LW    = mk_attr(5'd9,  5'd8,  1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        A_SW    = mk_attr(5'd11, 5'd10, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        A_OR6   = mk_attr(5'd7,  5'd8,  1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        A_BEQ   = mk_attr(5'd1,  5'd2,  1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        A_NOP   = '0;

        //               iv     pc0        inst0    a0       pc1        inst1    a1       ordy  fl    ov     cnt   rdy   pc0        inst0    pc1
        vecs[0]  = mk_vec(2'b11, 32'h1000, I_ADDU3, A_ADDU3, 32'h1004, I_ADDU5, A_ADDU5, 1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[1]  = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b01, 4'd2, 1'b1, 32'h1000,  I_ADDU3, 32'h0);
        vecs[2]  = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b01, 4'd1, 1'b1, 32'h1004,  I_ADDU5, 32'h0);
        vecs[3]  = mk_vec(2'b11, 32'h2000, I_LW,    A_LW,    32'h2004, I_SW,    A_SW,    1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[4]  = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b01, 4'd2, 1'b1, 32'h2000,  I_LW,    32'h0);
        vecs[5]  = mk_vec(2'b11, 32'h3000, I_ADDU3, A_ADDU3, 32'h3004, I_OR6,   A_OR6,   1'b1, 1'b0, 2'b01, 4'd1, 1'b1, 32'h2004,  I_SW,    32'h0);
        vecs[6]  = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b11, 4'd2, 1'b1, 32'h3000,  I_ADDU3, 32'h3004);
        vecs[7]  = mk_vec(2'b01, 32'h4000, I_BEQ,   A_BEQ,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[8]  = mk_vec(2'b01, 32'h4004, I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b00, 4'd1, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[9]  = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b11, 4'd2, 1'b1, 32'h4000,  I_BEQ,   32'h4004);
        vecs[10] = mk_vec(2'b11, 32'h5000, I_ADDU3, A_ADDU3, 32'h5004, I_OR6,   A_OR6,   1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[11] = mk_vec(2'b11, 32'h6000, I_NOP,   A_NOP,   32'h6004, I_NOP,   A_NOP,   1'b1, 1'b1, 2'b00, 4'd2, 1'b1, 32'h0,     I_NOP,   32'h0);
        vecs[12] = mk_vec(2'b00, 32'h0,    I_NOP,   A_NOP,   32'h0,    I_NOP,   A_NOP,   1'b1, 1'b0, 2'b00, 4'd0, 1'b1, 32'h0,     I_NOP,   32'h0);

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 2'b00;
        in_pc     = '0;
        in_inst   = '0;
        in_attr   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].pc0, vecs[i].inst0, vecs[i].a0,
                          vecs[i].pc1, vecs[i].inst1, vecs[i].a1, vecs[i].ordy, vecs[i].fl);
            checkOutput($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            checkOutput($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].exp_cnt));
            checkOutput($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            if (vecs[i].exp_ov[0]) begin
                checkOutput($sformatf("v%0d pc0", i), 64'(out_pc[31:0]), 64'(vecs[i].exp_pc0));
                checkOutput($sformatf("v%0d inst0", i), 64'(out_inst[31:0]), 64'(vecs[i].exp_inst0));
            end
            if (vecs[i].exp_ov[1]) begin
                checkOutput($sformatf("v%0d pc1", i), 64'(out_pc[63:32]), 64'(vecs[i].exp_pc1));
            end
        end

        // Fill to seven entries starting from an empty queue at index 0
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 32'h7000 + 32'(8 * i), I_NOP, A_NOP,
                          32'h7004 + 32'(8 * i), I_NOP, A_NOP, 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d count", i), 64'(count), 64'(2 * i));
        end
        applyStimulus(2'b01, 32'h7018, I_NOP, A_NOP, 32'h0, I_NOP, A_NOP, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'hDEAD, I_NOP, A_NOP, 32'hBEEF, I_NOP, A_NOP, 1'b0, 1'b0);
        checkOutput("full count", 64'(count), 64'd7);
        checkOutput("full in_ready", 64'(in_ready), 64'd0);
        checkOutput("full out_valid", 64'(out_valid), 64'd3);
        idleCycle(1'b0);
        checkOutput("full drop count", 64'(count), 64'd7);

        // Drain: three pairs, then the last entry alone leaves head at 7
        for (int k = 0; k < 4; k++) begin
            idleCycle(1'b1);
            checkOutput($sformatf("drain%0d pc0", k), 64'(out_pc[31:0]), 64'(32'h7000 + 32'(8 * k)));
            checkOutput($sformatf("drain%0d out_valid", k), 64'(out_valid), (k < 3) ? 64'd3 : 64'd1);
        end

        // Pair written at indices 7 and 0 and issued across the wrap
        applyStimulus(2'b11, 32'h8000, I_NOP, A_NOP, 32'h8004, I_NOP, A_NOP, 1'b0, 1'b0);
        checkOutput("wrap empty count", 64'(count), 64'd0);
        idleCycle(1'b1);
        checkOutput("wrap out_valid", 64'(out_valid), 64'd3);
        checkOutput("wrap pc0", 64'(out_pc[31:0]), 64'h8000);
        checkOutput("wrap pc1", 64'(out_pc[63:32]), 64'h8004);
        idleCycle(1'b0);
        checkOutput("wrap drained count", 64'(count), 64'd0);

        // Illegal slot-1-only valid pattern is ignored
        applyStimulus(2'b10, 32'hA000, I_NOP, A_NOP, 32'hA004, I_NOP, A_NOP, 1'b0, 1'b0);
        idleCycle(1'b0);
        checkOutput("illegal10 count", 64'(count), 64'd0);
        checkOutput("illegal10 out_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of operation discards queued entries
        applyStimulus(2'b11, 32'hB000, I_NOP, A_NOP, 32'hB004, I_NOP, A_NOP, 1'b0, 1'b0);
        idleCycle(1'b0);
        checkOutput("midreset pre count", 64'(count), 64'd2);
        rst_n = 1'b0;
        idleCycle(1'b0);
        rst_n = 1'b1;
        checkOutput("midreset count", 64'(count), 64'd0);
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset in_ready", 64'(in_ready), 64'd1);

        // Single-issue instance: branch issues alone at once, never a pair
        applyStimulus(2'b01, 32'h9000, I_BEQ, A_BEQ, 32'h0, I_NOP, A_NOP, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h9004, I_NOP, A_NOP, 32'h9008, I_NOP, A_NOP, 1'b0, 1'b0);
        checkOutput("si branch out_valid", 64'(si_out_valid), 64'd1);
        checkOutput("si branch pc0", 64'(si_out_pc[31:0]), 64'h9000);
        checkOutput("si branch count", 64'(si_count), 64'd1);
        checkOutput("dual branch hold", 64'(out_valid), 64'd0);
        idleCycle(1'b0);
        checkOutput("si three count", 64'(si_count), 64'd3);
        checkOutput("si three out_valid", 64'(si_out_valid), 64'd1);
        checkOutput("dual branch pair", 64'(out_valid), 64'd3);
        for (int k = 0; k < 3; k++) begin
            idleCycle(1'b1);
            checkOutput($sformatf("si issue%0d out_valid", k), 64'(si_out_valid), 64'd1);
            checkOutput($sformatf("si issue%0d pc0", k), 64'(si_out_pc[31:0]), 64'(32'h9000 + 32'(4 * k)));
        end
        idleCycle(1'b0);
        checkOutput("si drained count", 64'(si_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/idu_issue_queue.md
IDU_ISSUE_QUEUE -- requirements
Module: idu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of entries (power of two, >= 4).
REQ-002 Parameter DUAL_ISSUE, default 1, SHALL select the issue mode: 1 = up to two per cycle, 0 = single issue only.
REQ-003 Ports (clock and reset first); slot 0 is always the older instruction:
  clk  in  1  rising-edge clock.
  rst_n  in  1  reset; one clock, reset is synchronous and active-low.
  flush  in  1  discard all entries (exception, eret or mispredict).
  in_valid  in  2  enqueue slot valids; legal values 00, 01, 11.
  in_pc  in  64  {pc1, pc0}.
  in_inst  in  64  {inst1, inst0}.
  in_attr  in  2*ATTR_W  pre-decoded attribute bundles {a1, a0}.
  in_ready  out  1  queue can accept two entries.
  out_valid  out  2  issue slot valids; only 00, 01, 11 are produced.
  out_pc  out  64  head pcs.
  out_inst  out  64  head instructions.
  out_attr  out  2*ATTR_W  head attribute bundles.
  out_ready  in  1  downstream accepts every offered slot.
  count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-004 The attribute bundle (ATTR_W = 23) SHALL contain: rs[5], rt[5], w_ena, w_dst[5], is_branch (branch, j, jal, jr or jalr), is_ls, is_hilo, is_cop0 (including break and syscall), is_ri.
REQ-005 in_ready SHALL equal (DEPTH - count >= 2), combinational from registered state.
REQ-006 Enqueue SHALL fire when in_ready & in_valid[0]; slot 0 is written at tail, slot 1 (if valid) at tail+1, and tail advances by popcount(in_valid) modulo DEPTH.
REQ-007 There SHALL be no bypass: an entry is visible on out_* no earlier than the cycle after its enqueue.
REQ-008 out_* data SHALL be read combinationally from entries head and head+1 (modulo DEPTH).
REQ-009 out_valid[0] SHALL be 1 when count >= 1 and flush = 0, except in the branch hold case of REQ-012.
REQ-010 out_valid[1] SHALL be 1 only when all of the following hold:
  - DUAL_ISSUE = 1, count >= 2, out_valid[0] = 1;
  - pairing passes: NOT (a0.w_ena & a0.w_dst != 0 & (a1.rs == a0.w_dst | a1.rt == a0.w_dst));
  - NOT (a0.is_ls & a1.is_ls) and NOT (a0.is_hilo & a1.is_hilo);
  - none of a0/a1 .is_cop0/.is_ri is set;
  - a1.is_branch = 0.
REQ-011 A failed pairing SHALL issue slot 0 alone; the former entry at head+1 becomes slot 0 on the next cycle.
REQ-012 Branch hold (DUAL_ISSUE = 1): when a0.is_branch = 1 and count = 1, out_valid SHALL be 00 until the delay slot arrives; when count >= 2, the branch issues with its delay slot if the pairing passes, else alone.
REQ-013 Dequeue SHALL fire when out_ready & out_valid[0]; head advances by popcount(out_valid) modulo DEPTH.
REQ-014 When enqueue and dequeue happen in the same cycle, the next count SHALL be count + popcount(accepted in_valid) - popcount(out_valid).
REQ-015 head and tail SHALL wrap from DEPTH-1 to 0; a pair may straddle the wrap.
REQ-016 flush SHALL have priority over everything else:
  - the same cycle forces out_valid = 00 and drops any enqueue;
  - the next cycle has head = tail = count = 0.
REQ-017 Illegal in_valid = 10 SHALL be treated as 00.

Reset
REQ-018 When rst_n = 0 at a clock edge: head, tail and count SHALL be 0; hence out_valid = 00 and in_ready = 1 in the following cycle.
REQ-019 Entry storage SHALL NOT be reset.
REQ-020 A reset asserted mid-operation SHALL discard all entries, identically to flush.

Structure
REQ-021 ATTR_W, the attribute field offsets and the attribute struct SHALL live in the shared decode package, alongside the existing opcode/funct constants.
REQ-022 The pairing rules of REQ-010 to REQ-012 SHALL be a combinational sub-module idu_iq_pair_check (inputs a0, a1, count>=2, DUAL_ISSUE; output pair_ok, hold).

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
  - Reset, then enqueue {addu $3,$1,$2; addu $5,$3,$4} -> next cycle out_valid = 01 (RAW on $3); then out_valid = 01 with the second instruction.
  - Enqueue {lw; sw} -> issued singly; then {addu $3; or $6} -> out_valid = 11, count drops by 2.
  - Enqueue beq alone -> out_valid = 00 held; enqueue its delay slot nop -> out_valid = 11 next cycle.
  - DEPTH = 8: fill to count = 7 -> in_ready = 0; dequeue pairs across the wrap (head = 7, head+1 = 0) with correct pc order.
  - flush together with in_valid = 11 and out_ready = 1 -> count = 0, no entry issued or written, in_ready = 1 next cycle.
  - DUAL_ISSUE = 0 -> out_valid never 11; a branch at the head with count = 1 issues immediately.
